// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// Both directions use valid/ready handshakes.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] r;
  logic             c_out;

  modport master (
    output in_valid, a, b, carry_in, res_ready,
    input  in_ready, res_valid, r, c_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, res_ready,
    output in_ready, res_valid, r, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// The result is held in dedicated registers that change only on the final RUN edge.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus,
  output logic           busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic             in_ready;
  logic             res_valid;
  logic             sum_bit;
  logic             carry_nx;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  assign sum_bit  = fa_sum(a_sh[0], b_sh[0], carry);
  assign carry_nx = fa_carry(a_sh[0], b_sh[0], carry);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bit-serial datapath: one sum bit per RUN edge, result captured on the last one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.carry_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= {sum_bit, sum_sh[WIDTH-1:1]};
          carry  <= carry_nx;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (cnt == LAST) begin
            r_q <= {sum_bit, sum_sh[WIDTH-1:1]};
            c_q <= carry_nx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.r         = r_q;
  assign bus.c_out     = c_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, the additive counterpart of the team's ripple subtractor datapath.
- Accepts two operands plus carry-in over a valid/ready handshake.
- Computes a + b + carry_in one bit per clock, LSB first, using a single full-adder cell and a carry flop.
- Presents the result over a second valid/ready handshake; used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operands a, b, carry_in valid
in_ready  output  1  block can accept operands
a  input  WIDTH  addend A
b  input  WIDTH  addend B
carry_in  input  1  carry into bit 0
res_valid  output  1  r and c_out hold a completed result
res_ready  input  1  consumer accepts result
r  output  WIDTH  sum bits
c_out  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: on a clk edge with rst_n=0 -> state IDLE, bit counter 0, carry flop 0, operand shift registers 0.
  - Outputs after reset: in_ready=1, res_valid=0, busy=0, r=0, c_out=0.
  - Reset wins over every other event on the same edge, including mid-RUN and mid-DONE. Any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: latch a, b into shift registers, carry flop <= carry_in, counter <= 0, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0; in_valid and operand changes ignored.
  - Each edge: sum bit = a_sh[0] ^ b_sh[0] ^ carry, shifted into the MSB of the sum shift register (sum register shifts right).
  - carry <= majority(a_sh[0], b_sh[0], carry); a_sh, b_sh shift right by one; counter increments.
  - On the edge where counter == WIDTH-1: copy the completed sum to r and the final carry to c_out, go to DONE.
- DONE:
  - res_valid=1; r and c_out stable.
  - On edge with res_ready=1: go to IDLE. res_valid=0 and in_ready=1 from the next cycle.
  - res_ready=0: hold indefinitely (backpressure). No new operands accepted.
- Latency: accept edge E0; result visible after edge E(WIDTH); res_valid first high in the cycle after E(WIDTH), i.e. WIDTH cycles after the accept edge.
- Throughput: minimum issue interval is WIDTH+2 cycles. A new accept occurs no earlier than one IDLE cycle after the result handshake.
- r and c_out are dedicated output registers:
  - They keep the last completed result through IDLE and through the next RUN.
  - They update only on the final RUN edge.
  - They never show partial sums.
- res_ready asserted outside DONE has no effect.
- Arithmetic: r = (a + b + carry_in) mod 2^WIDTH; c_out = bit WIDTH of the full sum; unsigned, no overflow flag.
- Counter width: clog2(WIDTH). The counter never wraps past WIDTH-1.

Test Plan:
- Basic add, WIDTH=8: a=8'h3C, b=8'h05, carry_in=0 -> res_valid after 8 cycles; r=8'h41, c_out=0; busy high from the cycle after accept until the result handshake.
- Full carry ripple: a=8'hFF, b=8'h01, carry_in=0 -> r=8'h00, c_out=1. Then a=8'hFF, b=8'h00, carry_in=1 -> r=8'h00, c_out=1. Then a=8'h80, b=8'h80, carry_in=1 -> r=8'h01, c_out=1.
- Backpressure: a=8'h12, b=8'h34, res_ready=0 for 20 cycles.
  - Required: res_valid stays 1, r=8'h46 held, in_ready=0.
  - in_valid pulsed with a=8'hAA during the wait is ignored.
  - After res_ready=1 for one edge: IDLE, in_ready=1.
- Reset mid-operation: accept a=8'hF0, b=8'h0F. Drive rst_n=0 on the 4th RUN edge.
  - Required next cycle: IDLE, in_ready=1, res_valid=0, r=8'h00, c_out=0.
  - A following add 8'h01+8'h01 gives r=8'h02.
- Back-to-back with res_ready tied 1 and in_valid tied 1: operand pairs (8'h10,8'h20), (8'hFE,8'h03).
  - Required: results 8'h30/c_out 0, then 8'h01/c_out 1.
  - Each res_valid is a single-cycle pulse; accepts spaced exactly WIDTH+2 cycles apart.
- Parameter sweep WIDTH=2 and WIDTH=32 with random operands -> r and c_out match reference a+b+carry_in. Latency equals WIDTH cycles in every case.
